// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, class bit indices, the decoded bundle and the reference decode function.
// imm and pc are XMAX wide; in XLEN=32 builds their upper 32 bits are zero.
package riscv_pkg;
  localparam int XMAX = 64;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam int CLS_W = 11;
  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_S, CLS_B, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_OP32, CLS_OPIMM32
  } cls_e;
  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XMAX-1:0]  imm;
    logic [CLS_W-1:0] cls;
    logic             illegal;
    logic [XMAX-1:0]  pc;
  } decoded_t;
  function automatic decoded_t decode_word(input logic [31:0] instr, input logic [XMAX-1:0] pc,
                                           input int xlen, input logic m_ext);
    decoded_t d;
    logic [31:0] imm;
    logic f7_ok;
    logic rv64;
    d = '0;
    imm = '0;
    d.rd = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1 = instr[19:15];
    d.rs2 = instr[24:20];
    d.funct7 = instr[31:25];
    d.pc = pc;
    rv64 = xlen == 64;
    f7_ok = instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000 ||
            (m_ext && instr[31:25] == 7'b0000001);
    // every class opcode ends in 2'b11, so compressed encodings and the all-zero word fall to default
    case (instr[6:0])
      OPC_OP:      d.cls[CLS_R] = f7_ok;
      OPC_OP32:    d.cls[CLS_OP32] = rv64 && f7_ok;
      OPC_OPIMM:   begin d.cls[CLS_I] = 1'b1;           imm = {{20{instr[31]}}, instr[31:20]}; end
      OPC_LOAD:    begin d.cls[CLS_LOAD] = 1'b1;        imm = {{20{instr[31]}}, instr[31:20]}; end
      OPC_JALR:    begin d.cls[CLS_JALR] = 1'b1;        imm = {{20{instr[31]}}, instr[31:20]}; end
      OPC_OPIMM32: begin d.cls[CLS_OPIMM32] = rv64;     imm = {{20{instr[31]}}, instr[31:20]}; end
      OPC_STORE:   begin d.cls[CLS_S] = 1'b1;           imm = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
      OPC_BRANCH:  begin d.cls[CLS_B] = 1'b1;
                         imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}; end
      OPC_LUI:     begin d.cls[CLS_LUI] = 1'b1;         imm = {instr[31:12], 12'b0}; end
      OPC_AUIPC:   begin d.cls[CLS_AUIPC] = 1'b1;       imm = {instr[31:12], 12'b0}; end
      OPC_JAL:     begin d.cls[CLS_JAL] = 1'b1;
                         imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}; end
      default: ;
    endcase
    d.illegal = d.cls == '0;
    d.imm = d.illegal ? '0 : rv64 ? {{32{imm[31]}}, imm} : {32'b0, imm};
    return d;
  endfunction
endpackage

// File: rtl/riscv_decode_core.sv
// riscv_decode_core: combinational instruction word + pc -> decoded bundle.
module riscv_decode_core
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output decoded_t        o_dec
);
  logic [XMAX-1:0] w_pc;
  always_comb begin
    w_pc = '0;
    w_pc[XLEN-1:0] = i_pc;
  end
  always_comb o_dec = decode_word(i_instr, w_pc, XLEN, M_EXT);
endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered decode stage with valid/ready on both sides, optional skid, flush.
// The skid holds raw instr/pc; one decoder serves whichever of skid or input feeds the output register.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1,
  parameter bit SKID  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output decoded_t        out_dec
);
  logic            r_out_valid;
  logic            r_skid_valid;
  decoded_t        r_out;
  logic [31:0]     r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;
  logic            w_in_fire;
  logic            w_out_open;
  logic            w_load_out;
  logic            w_load_skid;
  logic [31:0]     w_instr;
  logic [XLEN-1:0] w_pc;
  decoded_t        w_dec;
  assign in_ready    = SKID ? !r_skid_valid : (!r_out_valid || out_ready);
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_open  = !r_out_valid || out_ready;
  assign w_load_out  = w_out_open && (r_skid_valid || w_in_fire);
  assign w_load_skid = SKID && !w_out_open && w_in_fire;
  // a held skid entry is older than anything on the input, so it always goes first
  assign w_instr     = r_skid_valid ? r_skid_instr : in_instr;
  assign w_pc        = r_skid_valid ? r_skid_pc : in_pc;
  assign out_valid   = r_out_valid;
  assign out_dec     = r_out;
  riscv_decode_core #(.XLEN(XLEN), .M_EXT(M_EXT)) u_core (
    .i_instr (w_instr),
    .i_pc    (w_pc),
    .o_dec   (w_dec)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_out_open) r_out_valid <= r_skid_valid || w_in_fire;
      if (w_load_out) r_out <= w_dec;
      r_skid_valid <= w_out_open ? 1'b0 : (r_skid_valid || w_load_skid);
      if (w_load_skid) begin
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc;
      end
    end
  end
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: three configurations (RV32+M+skid, RV64+M+skid, RV32 no-M no-skid) fed one
// shared stream; an occupancy queue per instance predicts out_valid, in_ready and each emitted bundle.
module tb_riscv_decode_stage;
  import riscv_pkg::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [31:0] in_instr = 0;
  logic [63:0] in_pc = 0;
  logic        in_ready [3];
  logic        out_valid [3];
  decoded_t    out_dec [3];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        acc0 = 0;
  decoded_t    q [3][$];
  int          fire_cyc [$];
  logic [63:0] fire_pc [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int XL = g == 1 ? 64 : 32;
    riscv_decode_stage #(.XLEN(XL), .M_EXT(g != 2), .SKID(g != 2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_instr(in_instr), .in_pc(in_pc[XL-1:0]), .out_valid(out_valid[g]),
      .out_ready(out_ready), .out_dec(out_dec[g])
    );
  end

  function automatic int xl_of(int i); return i == 1 ? 64 : 32; endfunction
  function automatic bit m_of(int i); return i != 2; endfunction
  function automatic bit skid_of(int i); return i != 2; endfunction

  // reference decode: field rules written directly as signed immediates
  function automatic decoded_t ref_dec(logic [31:0] w, logic [63:0] pc, int xl, bit m);
    decoded_t d = '0;
    logic [6:0] f7 = w[31:25];
    bit ok7 = f7 == 7'h00 || f7 == 7'h20 || (m && f7 == 7'h01);
    longint s = 0;
    int c = -1;
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = w[14:12]; d.funct7 = f7;
    d.pc = xl == 64 ? pc : {32'h0, pc[31:0]};
    case (w[6:0])
      7'h33: if (ok7) c = CLS_R;
      7'h3B: if (ok7 && xl == 64) c = CLS_OP32;
      7'h13: begin c = CLS_I;    s = longint'($signed(w[31:20])); end
      7'h03: begin c = CLS_LOAD; s = longint'($signed(w[31:20])); end
      7'h67: begin c = CLS_JALR; s = longint'($signed(w[31:20])); end
      7'h1B: if (xl == 64) begin c = CLS_OPIMM32; s = longint'($signed(w[31:20])); end
      7'h23: begin c = CLS_S;     s = longint'($signed({w[31:25], w[11:7]})); end
      7'h63: begin c = CLS_B;     s = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
      7'h37: begin c = CLS_LUI;   s = longint'($signed({w[31:12], 12'h000})); end
      7'h17: begin c = CLS_AUIPC; s = longint'($signed({w[31:12], 12'h000})); end
      7'h6F: begin c = CLS_JAL;   s = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      default: ;
    endcase
    if (c < 0) d.illegal = 1'b1;
    else begin
      d.cls[c] = 1'b1;
      d.imm = xl == 64 ? s : s & 64'hFFFF_FFFF;
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h3B, 7'h1B, 7'h00};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 3) == 0) return w;
    w[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  task automatic chk_dec(string n, decoded_t a, decoded_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h cls=%b ill=%b pc=%h, expected rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h cls=%b ill=%b pc=%h",
               n, a.rd, a.rs1, a.rs2, a.funct3, a.funct7, a.imm, a.cls, a.illegal, a.pc,
               e.rd, e.rs1, e.rs2, e.funct3, e.funct7, e.imm, e.cls, e.illegal, e.pc);
    end
  endtask

  // one cycle: compare at negedge against held-instruction queues, update them, then leave at posedge+1
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      bit fi;
      bit fo;
      fi = in_valid && in_ready[i];
      fo = out_valid[i] && out_ready;
      if (!rst_n) begin
        q[i].delete();
        chk($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
        if (skid_of(i)) chk($sformatf("rst_in_ready%0d", i), in_ready[i], 1);
        if (i == 0) acc0 = 0;
      end else begin
        chk($sformatf("out_valid%0d", i), out_valid[i], q[i].size() > 0);
        chk($sformatf("in_ready%0d", i), in_ready[i],
            skid_of(i) ? q[i].size() < 2 : (q[i].size() == 0 || out_ready));
        if (out_valid[i] && q[i].size() > 0) chk_dec($sformatf("dec%0d", i), out_dec[i], q[i][0]);
        if (i == 0) begin
          acc0 = fi && !flush;
          if (fo) begin
            fire_cyc.push_back(cyc);
            fire_pc.push_back(out_dec[0].pc);
          end
        end
        if (fo && q[i].size() > 0) void'(q[i].pop_front());
        if (flush) q[i].delete();
        else if (fi) q[i].push_back(ref_dec(in_instr, in_pc, xl_of(i), m_of(i)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send1(logic [31:0] w, logic [63:0] pc);
    in_valid = 1; in_instr = w; in_pc = pc;
    step();
    in_valid = 0;
  endtask

  initial begin
    decoded_t d;
    int k;
    int nacc;
    int n0;
    d = ref_dec(32'hFFF00093, 0, 32, 1);
    chk("pin_addi_imm", d.imm, 64'hFFFF_FFFF);
    chk("pin_addi_cls", d.cls, 1 << CLS_I);
    d = ref_dec(32'hFE000EE3, 0, 32, 1);
    chk("pin_beq_imm", d.imm, 64'hFFFF_FFFC);
    d = ref_dec(32'h800000B7, 0, 64, 1);
    chk("pin_lui64_imm", d.imm, 64'hFFFF_FFFF_8000_0000);
    d = ref_dec(32'h0000051B, 0, 32, 1);
    chk("pin_opimm32_on32", d.illegal, 1);
    d = ref_dec(32'h02000033, 0, 32, 0);
    chk("pin_mul_nom", d.illegal, 1);

    repeat (2) step();
    chk_dec("rst_out_dec", out_dec[0], '0);
    rst_n = 1;
    out_ready = 1;
    step();

    send1(32'hFFF00093, 64'h100);
    chk("t1_valid", out_valid[0], 1);
    chk("t1_cls", out_dec[0].cls, 1 << CLS_I);
    chk("t1_rd", out_dec[0].rd, 1);
    chk("t1_rs1", out_dec[0].rs1, 0);
    chk("t1_imm", out_dec[0].imm, 64'hFFFF_FFFF);
    send1(32'hFE000EE3, 64'h104);
    chk("t2_beq_cls", out_dec[0].cls, 1 << CLS_B);
    chk("t2_beq_imm", out_dec[0].imm, 64'hFFFF_FFFC);
    send1(32'h800000B7, 64'h108);
    chk("t2_lui64_imm", out_dec[1].imm, 64'hFFFF_FFFF_8000_0000);
    chk("t2_lui64_cls", out_dec[1].cls, 1 << CLS_LUI);
    send1(32'h0000051B, 64'h10C);
    chk("t2_opimm32_64", out_dec[1].cls, 1 << CLS_OPIMM32);
    chk("t2_opimm32_32_ill", out_dec[0].illegal, 1);
    chk("t2_opimm32_32_cls", out_dec[0].cls, 0);
    send1(32'h00000000, 64'h110);
    chk("t3_zero_ill", out_dec[0].illegal, 1);
    send1(32'h00000011, 64'h114);
    chk("t3_rvc_ill", out_dec[0].illegal, 1);
    chk("t3_rvc_cls", out_dec[0].cls, 0);
    chk("t3_rvc_pc", out_dec[0].pc, 64'h114);
    send1(32'h02000033, 64'h118);
    chk("t3_mul_m", out_dec[0].cls, 1 << CLS_R);
    chk("t3_mul_nom", out_dec[2].illegal, 1);
    step();

    fire_cyc.delete();
    fire_pc.delete();
    out_ready = 0;
    in_valid = 1;
    k = 0;
    nacc = 0;
    for (int c = 0; c < 3; c++) begin
      in_instr = {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
      in_pc = 64'h200 + 64'(4 * k);
      step();
      if (acc0) begin k++; nacc++; end
    end
    chk("t4_accepted", nacc, 2);
    chk("t4_in_ready_low", in_ready[0], 0);
    out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      in_valid = k < 4;
      in_instr = {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
      in_pc = 64'h200 + 64'(4 * k);
      step();
      if (acc0) k++;
    end
    in_valid = 0;
    chk("t4_out_count", fire_pc.size(), 4);
    if (fire_pc.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t4_order%0d", i), fire_pc[i], 64'h200 + 64'(4 * i));
      chk("t4_no_gaps", fire_cyc[3] - fire_cyc[0], 3);
    end

    out_ready = 0;
    in_valid = 1;
    for (int c = 0; c < 2; c++) begin
      in_instr = 32'h00500113 + (32'(c) << 20);
      in_pc = 64'h280 + 64'(4 * c);
      step();
    end
    in_instr = 32'h00700193;
    in_pc = 64'h2F0;
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    for (int i = 0; i < 3; i++) chk($sformatf("t5_flushed%0d", i), out_valid[i], 0);
    chk("t5_in_ready", in_ready[0], 1);
    out_ready = 1;
    send1(32'h00900213, 64'h300);
    chk("t5_next_valid", out_valid[0], 1);
    chk("t5_next_pc", out_dec[0].pc, 64'h300);
    step();

    out_ready = 0;
    in_valid = 1;
    for (int c = 0; c < 2; c++) begin
      in_instr = 32'h00100093;
      in_pc = 64'h400 + 64'(4 * c);
      step();
    end
    in_valid = 0;
    rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("t6_async%0d", i), out_valid[i], 0);
    repeat (2) step();
    rst_n = 1;
    out_ready = 1;
    repeat (3) step();
    chk("t6_no_pulse", out_valid[0], 0);

    n0 = 0;
    for (int c = 0; c < 18000; c++) begin
      in_valid = $urandom_range(0, 9) < 8;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 199) == 0;
      in_instr = rand_instr();
      in_pc = {$urandom, $urandom};
      step();
      if (acc0) n0++;
    end
    flush = 0;
    in_valid = 0;
    chk("stress_volume", n0 >= 10000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
